trigger_readout_ctrl: RTL

Buffers trigger IDs captured by the trigger block and sequences their readout to the MCU over the SPI block. Each buffered ID is presented one at a time on the SPI transmit word, with the active-low interrupt line asserted. The entry is retired when the SPI block signals a completed frame. The block also asserts a busy/veto output when the buffer nears full and keeps a saturating count of dropped triggers. It sits between the trigger and spi instances, in the sampling_clk (PLL) domain.

---
 rtl/trigger_readout_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/trigger_readout_ctrl.sv
// trigger_readout_ctrl
// Buffers captured trigger IDs in a small circular FIFO and hands them one
// at a time to the SPI block. The active-low interrupt tells the MCU that an
// ID is waiting on spi_data. A completed SPI frame retires the entry. After
// each readout the interrupt stays high for a fixed holdoff gap. The block
// also raises a busy/veto output when the buffer is nearly full, and keeps a
// saturating count of dropped triggers.
module trigger_readout_ctrl #(
  parameter int DEPTH    = 8,   // power of 2, >= 4
  parameter int ID_WIDTH = 16,
  parameter int HOLDOFF  = 4    // >= 1
) (
  input  logic                     sampling_clk,
  input  logic                     reset,          // async, active-low
  input  logic                     trig_valid,
  input  logic [ID_WIDTH-1:0]      trig_id_in,
  input  logic                     veto_in,
  input  logic                     spi_frame_done,
  output logic [ID_WIDTH-1:0]      spi_data,
  output logic                     interrupt,
  output logic                     veto_out,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(HOLDOFF + 1);

  localparam logic [FW-1:0] FULL_LVL  = FW'(DEPTH);
  localparam logic [FW-1:0] VETO_LVL  = FW'(DEPTH - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PRESENT,
    S_HOLDOFF
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CW-1:0]       r_hold_cnt;
  logic [CW-1:0]       w_hold_cnt_next;

  logic [ID_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [FW-1:0]       r_fill;
  logic [FW-1:0]       w_fill_next;

  logic [ID_WIDTH-1:0] r_spi_data;
  logic                r_interrupt;
  logic                r_veto;
  logic [7:0]          r_drop_count;

  logic                w_full;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;

  // Full is judged on the registered occupancy, so a push that meets a full
  // buffer is lost even when a pop frees a slot on the same edge.
  assign w_full = (r_fill == FULL_LVL);
  assign w_push = trig_valid & ~veto_in & ~w_full;
  assign w_drop = trig_valid & ~w_push;
  assign w_pop  = spi_frame_done & (r_state == S_PRESENT);

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_fill_next = r_fill;
    case ({w_push, w_pop})
      2'b10:   w_fill_next = r_fill + FW'(1);
      2'b01:   w_fill_next = r_fill - FW'(1);
      default: w_fill_next = r_fill;
    endcase
  end

  // FIFO storage write port (no reset so it maps onto RAM).
  always_ff @(posedge sampling_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= trig_id_in;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge sampling_clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_fill <= w_fill_next;
    end
  end

  // Busy/veto follows the new occupancy so it changes with fill_level.
  always_ff @(posedge sampling_clk or negedge reset) begin
    if (!reset) begin
      r_veto <= 1'b0;
    end else begin
      r_veto <= (w_fill_next >= VETO_LVL);
    end
  end

  // Saturating count of triggers lost to veto_in or a full buffer.
  always_ff @(posedge sampling_clk or negedge reset) begin
    if (!reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  // Readout sequencer next-state logic. The holdoff counter is loaded on
  // the pop and the state is left once it has counted down to zero.
  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (r_fill != '0) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_next = S_PRESENT;
      end
      S_PRESENT: begin
        if (spi_frame_done) begin
          w_state_next    = S_HOLDOFF;
          w_hold_cnt_next = HOLD_LOAD;
        end
      end
      S_HOLDOFF: begin
        if (r_hold_cnt == '0) begin
          w_state_next = (r_fill != '0) ? S_LOAD : S_IDLE;
        end else begin
          w_hold_cnt_next = r_hold_cnt - CW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Sequencer state and holdoff counter registers.
  always_ff @(posedge sampling_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
    end
  end

  // Head entry is latched in LOAD and then held until the next LOAD, so the
  // MCU sees a stable word for the whole presentation and afterwards.
  always_ff @(posedge sampling_clk or negedge reset) begin
    if (!reset) begin
      r_spi_data <= '0;
    end else if (r_state == S_LOAD) begin
      r_spi_data <= r_mem[r_rd_ptr];
    end
  end

  // Interrupt registered from the next state to keep the pin glitch-free.
  always_ff @(posedge sampling_clk or negedge reset) begin
    if (!reset) begin
      r_interrupt <= 1'b1;
    end else begin
      r_interrupt <= (w_state_next != S_PRESENT);
    end
  end

  assign spi_data   = r_spi_data;
  assign interrupt  = r_interrupt;
  assign veto_out   = r_veto;
  assign fill_level = r_fill;
  assign drop_count = r_drop_count;

endmodule
